uart_tx_core: RTL and testbench

- UART transmit core: the transmit counterpart of the UART RX path in the low-power multi-clock system.
- Accepts a parallel byte with a one-cycle valid strobe and serialises it onto TX_OUT as one frame: start bit, 8 data bits LSB first, optional even/odd parity bit, one stop bit.
- Runs on the divided TX clock, so one CLK cycle equals one bit period.
- Sits between the async-FIFO read side (the data source) and the TX pad.

---
 rtl/uart_tx_core.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_core.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// UART transmit core: serialises one byte per frame (start, data LSB first, optional parity, stop).
// Optional one-entry holding register for back-to-back frames when UART_TX_HOLD_EN is defined.
module uart_tx_core #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic                  HOLD_FULL
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  state, state_nxt;
    logic [DATA_WIDTH-1:0]   shift, shift_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic                    par_en, par_en_nxt;
    logic                    par_bit, par_bit_nxt;
    logic                    tx_nxt;
    logic                    load;
    logic                    start_req;
    logic [DATA_WIDTH-1:0]   src_data;
    logic                    src_par_en;
    logic                    src_par_typ;

`ifdef UART_TX_HOLD_EN
    logic [DATA_WIDTH-1:0]   hold_data, hold_data_nxt;
    logic                    hold_par_en, hold_par_en_nxt;
    logic                    hold_par_typ, hold_par_typ_nxt;
    logic                    hold_full, hold_full_nxt;

    // A held word takes priority over the live inputs when a frame is started.
    always_comb begin
        start_req   = hold_full | DATA_VALID;
        src_data    = hold_full ? hold_data    : P_DATA;
        src_par_en  = hold_full ? hold_par_en  : PAR_EN;
        src_par_typ = hold_full ? hold_par_typ : PAR_TYP;
    end

    assign HOLD_FULL = hold_full;
`else
    always_comb begin
        start_req   = DATA_VALID;
        src_data    = P_DATA;
        src_par_en  = PAR_EN;
        src_par_typ = PAR_TYP;
    end

    assign HOLD_FULL = 1'b0;
`endif

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        cnt_nxt     = cnt;
        par_en_nxt  = par_en;
        par_bit_nxt = par_bit;
        load        = 1'b0;
        tx_nxt      = 1'b1;
`ifdef UART_TX_HOLD_EN
        hold_data_nxt    = hold_data;
        hold_par_en_nxt  = hold_par_en;
        hold_par_typ_nxt = hold_par_typ;
        hold_full_nxt    = hold_full;
`endif

        case (state)
            IDLE:   load = start_req;
            START:  state_nxt = DATA;
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = {CNT_W{1'b0}};
                    state_nxt = par_en ? PARITY : STOP;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                    shift_nxt = shift >> 1;
                end
            end
            PARITY: state_nxt = STOP;
            STOP: begin
                state_nxt = IDLE;
`ifdef UART_TX_HOLD_EN
                load = hold_full;
`endif
            end
            default: state_nxt = IDLE;
        endcase

        if (load) begin
            state_nxt   = START;
            shift_nxt   = src_data;
            par_en_nxt  = src_par_en;
            par_bit_nxt = (^src_data) ^ src_par_typ;
            cnt_nxt     = {CNT_W{1'b0}};
        end

`ifdef UART_TX_HOLD_EN
        // Capture needs an empty hold, so it never coincides with a load from hold.
        if (load && hold_full) begin
            hold_full_nxt = 1'b0;
        end else if ((state != IDLE) && !hold_full && DATA_VALID) begin
            hold_data_nxt    = P_DATA;
            hold_par_en_nxt  = PAR_EN;
            hold_par_typ_nxt = PAR_TYP;
            hold_full_nxt    = 1'b1;
        end
`endif

        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            PARITY:  tx_nxt = par_bit_nxt;
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            shift   <= {DATA_WIDTH{1'b0}};
            cnt     <= {CNT_W{1'b0}};
            par_en  <= 1'b0;
            par_bit <= 1'b0;
            TX_OUT  <= 1'b1;
            BUSY    <= 1'b0;
        end else begin
            state   <= state_nxt;
            shift   <= shift_nxt;
            cnt     <= cnt_nxt;
            par_en  <= par_en_nxt;
            par_bit <= par_bit_nxt;
            TX_OUT  <= tx_nxt;
            BUSY    <= (state_nxt != IDLE);
        end
    end

`ifdef UART_TX_HOLD_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hold_data    <= {DATA_WIDTH{1'b0}};
            hold_par_en  <= 1'b0;
            hold_par_typ <= 1'b0;
            hold_full    <= 1'b0;
        end else begin
            hold_data    <= hold_data_nxt;
            hold_par_en  <= hold_par_en_nxt;
            hold_par_typ <= hold_par_typ_nxt;
            hold_full    <= hold_full_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed self-checking bench for uart_tx_core; frame bit vectors are hand-computed as {stop, [parity], data, start}.
module tb_uart_tx_core;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       BUSY;
    logic       HOLD_FULL;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_core #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .BUSY       (BUSY),
        .HOLD_FULL  (HOLD_FULL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_tx"}, TX_OUT, 1'b1);
        chk({tag, "_busy"}, BUSY, 1'b0);
        chk({tag, "_hold"}, HOLD_FULL, 1'b0);
    endtask

    // Raise the strobe at a falling edge; the next rising edge accepts it.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt);
        @(negedge CLK);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        DATA_VALID = 1'b1;
    endtask

    // bits[i] is the i-th bit on the line; inputs are scrambled mid-frame to prove they were latched.
    task automatic expect_frame(input string tag, input logic [10:0] bits, input int len);
        for (int i = 0; i < len; i++) begin
            @(negedge CLK);
            if (i == 0) DATA_VALID = 1'b0;
            if (i == 2) begin
                P_DATA  = ~P_DATA;
                PAR_EN  = ~PAR_EN;
                PAR_TYP = ~PAR_TYP;
            end
            chk($sformatf("%s_bit%0d", tag, i), TX_OUT, bits[i]);
            chk($sformatf("%s_busy%0d", tag, i), BUSY, 1'b1);
        end
        @(negedge CLK);
        chk_idle({tag, "_end"});
    endtask

    initial begin
        RST        = 1'b0;
        P_DATA     = 8'h00;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;

        // Reset state and idle line.
        #12;
        chk_idle("in_reset");
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk_idle($sformatf("idle%0d", i));
        end

        // 0xA5 without parity: 0,1,0,1,0,0,1,0,1,1.
        send(8'hA5, 1'b0, 1'b0);
        expect_frame("a5_np", 11'b0_1_10100101_0, 10);

        send(8'hA5, 1'b1, 1'b0);
        expect_frame("a5_even", 11'b1_0_10100101_0, 11);

        send(8'hA5, 1'b1, 1'b1);
        expect_frame("a5_odd", 11'b1_1_10100101_0, 11);

        send(8'h01, 1'b1, 1'b0);
        expect_frame("01_even", 11'b1_1_00000001_0, 11);

        send(8'h01, 1'b1, 1'b1);
        expect_frame("01_odd", 11'b1_0_00000001_0, 11);

        send(8'h00, 1'b0, 1'b0);
        expect_frame("00_np", 11'b0_1_00000000_0, 10);

`ifndef UART_TX_HOLD_EN
        // A strobe mid-frame is dropped; no second frame follows.
        send(8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            DATA_VALID = 1'b0;
            if (i == 3) begin
                P_DATA     = 8'h3C;
                PAR_EN     = 1'b1;
                DATA_VALID = 1'b1;
            end
            chk($sformatf("ff_bit%0d", i), TX_OUT, (i == 0) ? 1'b0 : 1'b1);
            chk($sformatf("ff_busy%0d", i), BUSY, 1'b1);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            chk_idle($sformatf("ff_after%0d", i));
        end
`else
        // Back-to-back: 0x55 then held 0x0F with no idle gap; third strobe while full is dropped.
        begin
            logic [19:0] seq;
            seq = 20'b1_00001111_0_1_01010101_0;
            send(8'h55, 1'b0, 1'b0);
            for (int i = 0; i < 20; i++) begin
                @(negedge CLK);
                DATA_VALID = 1'b0;
                if (i == 3) begin
                    P_DATA     = 8'h0F;
                    PAR_EN     = 1'b0;
                    DATA_VALID = 1'b1;
                end
                if (i == 6) begin
                    P_DATA     = 8'hAA;
                    PAR_EN     = 1'b1;
                    DATA_VALID = 1'b1;
                end
                chk($sformatf("hold_bit%0d", i), TX_OUT, seq[i]);
                chk($sformatf("hold_busy%0d", i), BUSY, 1'b1);
                chk($sformatf("hold_full%0d", i), HOLD_FULL, (i >= 4 && i <= 9) ? 1'b1 : 1'b0);
            end
            for (int i = 0; i < 12; i++) begin
                @(negedge CLK);
                chk_idle($sformatf("hold_after%0d", i));
            end
        end
`endif

        // Reset mid-frame returns the line to idle immediately.
        send(8'hA5, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            DATA_VALID = 1'b0;
        end
        chk("pre_rst_busy", BUSY, 1'b1);
        chk("pre_rst_tx", TX_OUT, 1'b0);
        #1;
        RST = 1'b0;
        #1;
        chk_idle("mid_rst");
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk_idle($sformatf("post_rst%0d", i));
        end

        // Frame after reset recovery.
        send(8'h3C, 1'b1, 1'b0);
        expect_frame("3c_even", 11'b1_0_00111100_0, 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
